// File: rtl/tinyqv_uart_tx_arbiter.sv
// tinyqv_uart_tx_arbiter: round-robin sharing of one UART transmitter between a CPU FIFO and a trace FIFO
//  Ports: clk/rst (async, active high); i_cpu_wr_en/i_cpu_wr_data push FIFO0, o_cpu_full;
//  i_trc_valid/i_trc_data push FIFO1 when o_trc_ready; o_tx_en/o_tx_data/i_tx_busy UART handshake;
//  o_ovf_sticky/i_ovf_clr/o_ovf_count CPU overflow status; o_idle nothing queued or in flight.
//  Define TINYQV_UART_ARB_OVF_CNT_EN to build the saturating drop counter behind o_ovf_count.
module tinyqv_uart_tx_arbiter #(
  parameter int DEPTH   = 4,
  parameter int BUSY_TO = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cpu_wr_en,
  input  logic [7:0] i_cpu_wr_data,
  output logic       o_cpu_full,
  input  logic       i_trc_valid,
  input  logic [7:0] i_trc_data,
  output logic       o_trc_ready,
  output logic       o_tx_en,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_ovf_sticky,
  input  logic       i_ovf_clr,
  output logic [7:0] o_ovf_count,
  output logic       o_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(BUSY_TO + 1);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} state_t;
  state_t r_state, w_nxt;
  logic [7:0] r_mem0 [DEPTH];
  logic [7:0] r_mem1 [DEPTH];
  logic [PW-1:0] r_wp0, r_rp0, r_wp1, r_rp1;
  logic [TW-1:0] r_to;
  logic [7:0] r_tx_data, w_head;
  logic r_rr, r_ovf;
  logic w_empty0, w_empty1, w_full0, w_full1, w_push0, w_push1, w_drop, w_grant, w_pop0, w_pop1;
  assign w_empty0 = r_wp0 == r_rp0;
  assign w_empty1 = r_wp1 == r_rp1;
  assign w_full0  = (r_wp0[AW] != r_rp0[AW]) && (r_wp0[AW-1:0] == r_rp0[AW-1:0]);
  assign w_full1  = (r_wp1[AW] != r_rp1[AW]) && (r_wp1[AW-1:0] == r_rp1[AW-1:0]);
  // full is sampled before any same-cycle pop, so a push into a full FIFO is dropped
  assign w_push0  = i_cpu_wr_en && !w_full0;
  assign w_drop   = i_cpu_wr_en && w_full0;
  assign w_push1  = i_trc_valid && !w_full1;
  // rr names the preferred port; fall back to the other one when it is empty
  assign w_grant  = r_rr ? !w_empty1 : w_empty0;
  assign w_head   = w_grant ? r_mem1[r_rp1[AW-1:0]] : r_mem0[r_rp0[AW-1:0]];
  assign o_cpu_full   = w_full0;
  assign o_trc_ready  = !w_full1;
  assign o_tx_data    = r_tx_data;
  assign o_ovf_sticky = r_ovf;
  assign o_idle       = w_empty0 && w_empty1 && (r_state == S_IDLE);
  always_comb begin
    w_nxt   = r_state;
    w_pop0  = 1'b0;
    w_pop1  = 1'b0;
    o_tx_en = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty0 || !w_empty1) begin
        w_nxt  = S_LAUNCH;
        w_pop0 = !w_grant;
        w_pop1 = w_grant;
      end
      S_LAUNCH: begin
        o_tx_en = 1'b1;
        w_nxt   = S_WAIT_HI;
      end
      S_WAIT_HI: w_nxt = i_tx_busy ? S_WAIT_LO : (r_to == TW'(BUSY_TO - 1)) ? S_IDLE : S_WAIT_HI;
      S_WAIT_LO: w_nxt = i_tx_busy ? S_WAIT_LO : S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wp0[AW-1:0]] <= i_cpu_wr_data;
    if (w_push1) r_mem1[r_wp1[AW-1:0]] <= i_trc_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_to      <= '0;
      r_wp0     <= '0;
      r_rp0     <= '0;
      r_wp1     <= '0;
      r_rp1     <= '0;
      r_rr      <= 1'b0;
      r_tx_data <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_to    <= (r_state == S_WAIT_HI) ? r_to + TW'(1) : '0;
      if (w_push0) r_wp0 <= r_wp0 + PW'(1);
      if (w_push1) r_wp1 <= r_wp1 + PW'(1);
      if (w_pop0) r_rp0 <= r_rp0 + PW'(1);
      if (w_pop1) r_rp1 <= r_rp1 + PW'(1);
      if (w_pop0 || w_pop1) begin
        r_tx_data <= w_head;
        r_rr      <= !w_grant;
      end
      r_ovf <= w_drop || (r_ovf && !i_ovf_clr);
    end
  end
`ifdef TINYQV_UART_ARB_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf_cnt <= 8'h00;
    else if (w_drop) r_ovf_cnt <= i_ovf_clr ? 8'h01 : r_ovf_cnt + {7'd0, r_ovf_cnt != 8'hFF};
    else if (i_ovf_clr) r_ovf_cnt <= 8'h00;
  end
  assign o_ovf_count = r_ovf_cnt;
`else
  assign o_ovf_count = 8'h00;
`endif
endmodule

// File: tb/tb_tinyqv_uart_tx_arbiter.sv
// tb_tinyqv_uart_tx_arbiter: directed scenarios plus a randomized queue-level reference model
`timescale 1ns/1ps
module tb_tinyqv_uart_tx_arbiter;
  localparam int DEPTH = 4;
`ifdef TINYQV_UART_ARB_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic i_cpu_wr_en = 1'b0, i_trc_valid = 1'b0, i_ovf_clr = 1'b0, i_tx_busy;
  logic [7:0] i_cpu_wr_data = 8'h00, i_trc_data = 8'h00;
  logic o_cpu_full, o_trc_ready, o_tx_en, o_ovf_sticky, o_idle;
  logic [7:0] o_tx_data, o_ovf_count;
  int tests = 0, fails = 0, cyc = 0;
  logic force_busy = 1'b0;
  int busy_len = 16, busy_left = 0;

  tinyqv_uart_tx_arbiter #(.DEPTH(DEPTH), .BUSY_TO(3)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_wr_en(i_cpu_wr_en), .i_cpu_wr_data(i_cpu_wr_data), .o_cpu_full(o_cpu_full),
    .i_trc_valid(i_trc_valid), .i_trc_data(i_trc_data), .o_trc_ready(o_trc_ready),
    .o_tx_en(o_tx_en), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .o_ovf_sticky(o_ovf_sticky), .i_ovf_clr(i_ovf_clr), .o_ovf_count(o_ovf_count), .o_idle(o_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // UART stand-in: busy starts the cycle after tx_en and lasts busy_len cycles (0 = never busy)
  always @(posedge clk or posedge rst)
    if (rst) busy_left <= 0;
    else if (o_tx_en === 1'b1) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  assign i_tx_busy = force_busy || (busy_left > 0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    i_cpu_wr_en = 1'b0; i_trc_valid = 1'b0; i_ovf_clr = 1'b0; force_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_cpu(input logic [7:0] d);
    i_cpu_wr_en = 1'b1; i_cpu_wr_data = d;
    @(negedge clk);
    i_cpu_wr_en = 1'b0;
  endtask

  task automatic wait_tx_en(input string name);
    int n = 0;
    while (o_tx_en !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    tests++;
    if (o_tx_en !== 1'b1) begin fails++; $display("FAIL %s_launch tx_en got %b want 1", name, o_tx_en); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests += 7;
    if (o_tx_en !== 1'b0)      begin fails++; $display("FAIL reset_tx_en got %b want 0", o_tx_en); end
    if (o_tx_data !== 8'h00)   begin fails++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
    if (o_cpu_full !== 1'b0)   begin fails++; $display("FAIL reset_cpu_full got %b want 0", o_cpu_full); end
    if (o_trc_ready !== 1'b1)  begin fails++; $display("FAIL reset_trc_ready got %b want 1", o_trc_ready); end
    if (o_ovf_sticky !== 1'b0) begin fails++; $display("FAIL reset_ovf_sticky got %b want 0", o_ovf_sticky); end
    if (o_ovf_count !== 8'h00) begin fails++; $display("FAIL reset_ovf_count got %h want 00", o_ovf_count); end
    if (o_idle !== 1'b1)       begin fails++; $display("FAIL reset_idle got %b want 1", o_idle); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c0, n = 0, t = -1;
    logic [7:0] d = 8'h00;
    apply_reset();
    busy_len = 16;
    c0 = cyc;
    push_cpu(8'h41);
    repeat (40) begin
      if (o_tx_en === 1'b1) begin n++; t = cyc; d = o_tx_data; end
      @(negedge clk);
    end
    tests += 5;
    if (n != 1)            begin fails++; $display("FAIL single_count got %0d want 1", n); end
    if (t != c0 + 2)       begin fails++; $display("FAIL single_latency got %0d want %0d", t - c0, 2); end
    if (d !== 8'h41)       begin fails++; $display("FAIL single_data got %h want 41", d); end
    if (o_tx_data !== 8'h41) begin fails++; $display("FAIL single_hold got %h want 41", o_tx_data); end
    if (o_idle !== 1'b1)   begin fails++; $display("FAIL single_idle got %b want 1", o_idle); end
  endtask

  task automatic test_order();
    logic [7:0] want [4] = '{8'h10, 8'h20, 8'h11, 8'h21};
    logic [7:0] got [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int n = 0;
    apply_reset();
    busy_len = 4;
    i_cpu_wr_en = 1'b1; i_cpu_wr_data = 8'h10; i_trc_valid = 1'b1; i_trc_data = 8'h20;
    @(negedge clk);
    i_cpu_wr_data = 8'h11; i_trc_data = 8'h21;
    @(negedge clk);
    i_cpu_wr_en = 1'b0; i_trc_valid = 1'b0;
    repeat (80) begin
      if (o_tx_en === 1'b1) begin if (n < 4) got[n] = o_tx_data; n++; end
      @(negedge clk);
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL order_count got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== want[i]) begin fails++; $display("FAIL order_byte%0d got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int n = 0;
    apply_reset();
    force_busy = 1'b1;
    push_cpu(8'hAA);
    wait_tx_en("ovf");
    for (int i = 1; i <= 5; i++) begin
      push_cpu(8'(i));
      if (i == 3) begin tests++; if (o_cpu_full !== 1'b0) begin fails++; $display("FAIL ovf_full3 got %b want 0", o_cpu_full); end end
      if (i == 4) begin tests++; if (o_cpu_full !== 1'b1) begin fails++; $display("FAIL ovf_full4 got %b want 1", o_cpu_full); end end
    end
    tests += 2;
    if (o_ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", o_ovf_sticky); end
    if (o_ovf_count !== (CNT_EN ? 8'h01 : 8'h00)) begin fails++; $display("FAIL ovf_count got %h want %h", o_ovf_count, CNT_EN ? 8'h01 : 8'h00); end
    force_busy = 1'b0;
    busy_len = 3;
    repeat (80) begin
      if (o_tx_en === 1'b1) begin if (n < 4) got[n] = o_tx_data; n++; end
      @(negedge clk);
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL ovf_drain_count got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL ovf_drain%0d got %h want %h", i, got[i], 8'(i + 1)); end
    end
    i_ovf_clr = 1'b1;
    @(negedge clk);
    i_ovf_clr = 1'b0;
    tests += 2;
    if (o_ovf_sticky !== 1'b0) begin fails++; $display("FAIL ovf_clr_sticky got %b want 0", o_ovf_sticky); end
    if (o_ovf_count !== 8'h00) begin fails++; $display("FAIL ovf_clr_count got %h want 00", o_ovf_count); end
  endtask

  task automatic test_timeout();
    int c0, n = 0;
    int t [2] = '{-1, -1};
    logic [7:0] d [2] = '{8'h00, 8'h00};
    apply_reset();
    busy_len = 0;
    c0 = cyc;
    push_cpu(8'h33);
    push_cpu(8'h34);
    repeat (40) begin
      if (o_tx_en === 1'b1) begin if (n < 2) begin t[n] = cyc; d[n] = o_tx_data; end n++; end
      @(negedge clk);
    end
    tests += 6;
    if (n != 2)         begin fails++; $display("FAIL timeout_count got %0d want 2", n); end
    if (t[0] != c0 + 2) begin fails++; $display("FAIL timeout_first_lat got %0d want 2", t[0] - c0); end
    if (t[1] != t[0] + 5) begin fails++; $display("FAIL timeout_gap got %0d want 5", t[1] - t[0]); end
    if (d[0] !== 8'h33) begin fails++; $display("FAIL timeout_d0 got %h want 33", d[0]); end
    if (d[1] !== 8'h34) begin fails++; $display("FAIL timeout_d1 got %h want 34", d[1]); end
    if (o_idle !== 1'b1) begin fails++; $display("FAIL timeout_idle got %b want 1", o_idle); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    force_busy = 1'b1;
    push_cpu(8'hAB);
    wait_tx_en("rstmid");
    push_cpu(8'hC1);
    push_cpu(8'hC2);
    push_cpu(8'hC3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests += 7;
    if (o_tx_en !== 1'b0)      begin fails++; $display("FAIL rstmid_tx_en got %b want 0", o_tx_en); end
    if (o_tx_data !== 8'h00)   begin fails++; $display("FAIL rstmid_tx_data got %h want 00", o_tx_data); end
    if (o_cpu_full !== 1'b0)   begin fails++; $display("FAIL rstmid_cpu_full got %b want 0", o_cpu_full); end
    if (o_trc_ready !== 1'b1)  begin fails++; $display("FAIL rstmid_trc_ready got %b want 1", o_trc_ready); end
    if (o_ovf_sticky !== 1'b0) begin fails++; $display("FAIL rstmid_sticky got %b want 0", o_ovf_sticky); end
    if (o_ovf_count !== 8'h00) begin fails++; $display("FAIL rstmid_count got %h want 00", o_ovf_count); end
    if (o_idle !== 1'b1)       begin fails++; $display("FAIL rstmid_idle got %b want 1", o_idle); end
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    repeat (20) begin
      if (o_tx_en === 1'b1) n++;
      @(negedge clk);
    end
    tests += 2;
    if (n != 0)          begin fails++; $display("FAIL rstmid_no_tx got %0d want 0", n); end
    if (o_idle !== 1'b1) begin fails++; $display("FAIL rstmid_idle_after got %b want 1", o_idle); end
  endtask

  task automatic test_ovf_count();
    apply_reset();
    force_busy = 1'b1;
    push_cpu(8'hAA);
    wait_tx_en("cnt");
    i_cpu_wr_en = 1'b1;
    repeat (DEPTH + 300) begin
      i_cpu_wr_data = 8'($urandom);
      @(negedge clk);
    end
    tests += 2;
    if (o_ovf_count !== (CNT_EN ? 8'hFF : 8'h00)) begin fails++; $display("FAIL cnt_sat got %h want %h", o_ovf_count, CNT_EN ? 8'hFF : 8'h00); end
    if (o_ovf_sticky !== 1'b1) begin fails++; $display("FAIL cnt_sticky got %b want 1", o_ovf_sticky); end
    i_ovf_clr = 1'b1;
    @(negedge clk);
    tests += 2;
    if (o_ovf_count !== (CNT_EN ? 8'h01 : 8'h00)) begin fails++; $display("FAIL cnt_clr_drop got %h want %h", o_ovf_count, CNT_EN ? 8'h01 : 8'h00); end
    if (o_ovf_sticky !== 1'b1) begin fails++; $display("FAIL cnt_clr_drop_sticky got %b want 1", o_ovf_sticky); end
    i_cpu_wr_en = 1'b0;
    @(negedge clk);
    i_ovf_clr = 1'b0;
    tests += 2;
    if (o_ovf_count !== 8'h00) begin fails++; $display("FAIL cnt_clr got %h want 00", o_ovf_count); end
    if (o_ovf_sticky !== 1'b0) begin fails++; $display("FAIL cnt_clr_sticky got %b want 0", o_ovf_sticky); end
    force_busy = 1'b0;
  endtask

  // Reference model: per-port queues of (byte, push cycle). A byte pushed while the
  // bench is in cycle c can be granted in c+1 and shows up on tx_en in c+2. Round robin
  // prefers the loser of the previous grant.
  task automatic test_random();
    logic [7:0] q0 [$], q1 [$];
    int s0 [$], s1 [$];
    bit rr = 1'b0, ovf = 1'b0, e0, e1, g, wr, tv, clr, drop;
    int cnt = 0;
    logic [7:0] want, d, td;
    apply_reset();
    for (int i = 0; i < 700; i++) begin
      if (o_tx_en === 1'b1) begin
        e0 = q0.size() > 0 && s0[0] <= cyc - 2;
        e1 = q1.size() > 0 && s1[0] <= cyc - 2;
        tests++;
        if (!e0 && !e1) begin
          fails++; $display("FAIL rand_spurious_tx cycle %0d got %h want no launch", cyc, o_tx_data);
        end else begin
          g = rr ? e1 : !e0;
          if (g) begin want = q1.pop_front(); void'(s1.pop_front()); end
          else begin want = q0.pop_front(); void'(s0.pop_front()); end
          rr = !g;
          if (o_tx_data !== want) begin fails++; $display("FAIL rand_tx_data cycle %0d got %h want %h", cyc, o_tx_data, want); end
        end
      end
      tests += 4;
      if (o_cpu_full !== (q0.size() == DEPTH)) begin fails++; $display("FAIL rand_cpu_full cycle %0d got %b want %b", cyc, o_cpu_full, q0.size() == DEPTH); end
      if (o_trc_ready !== (q1.size() < DEPTH)) begin fails++; $display("FAIL rand_trc_ready cycle %0d got %b want %b", cyc, o_trc_ready, q1.size() < DEPTH); end
      if (o_ovf_sticky !== ovf) begin fails++; $display("FAIL rand_sticky cycle %0d got %b want %b", cyc, o_ovf_sticky, ovf); end
      if (o_ovf_count !== 8'(cnt)) begin fails++; $display("FAIL rand_count cycle %0d got %h want %h", cyc, o_ovf_count, 8'(cnt)); end
      wr = 1'b0; tv = 1'b0; clr = 1'b0; d = 8'($urandom); td = 8'($urandom);
      if (i < 500) begin
        wr = ($urandom % 3) == 0;
        tv = ($urandom % 2) == 0;
        clr = ($urandom % 16) == 0;
        busy_len = $urandom_range(0, 5);
      end
      i_cpu_wr_en = wr; i_cpu_wr_data = d; i_trc_valid = tv; i_trc_data = td; i_ovf_clr = clr;
      drop = wr && q0.size() == DEPTH;
      if (wr && !drop) begin q0.push_back(d); s0.push_back(cyc); end
      if (tv && q1.size() < DEPTH) begin q1.push_back(td); s1.push_back(cyc); end
      if (drop) ovf = 1'b1; else if (clr) ovf = 1'b0;
      if (CNT_EN) cnt = drop ? (clr ? 1 : (cnt < 255 ? cnt + 1 : 255)) : (clr ? 0 : cnt);
      @(negedge clk);
    end
    tests += 2;
    if (q0.size() + q1.size() != 0) begin fails++; $display("FAIL rand_undelivered got %0d want 0", q0.size() + q1.size()); end
    if (o_idle !== 1'b1) begin fails++; $display("FAIL rand_idle got %b want 1", o_idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_ovf_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
